// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state encoding and owner IDs shared by the memory arbiter files
package mem_arb_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;
endpackage

// File: rtl/mem_arb_priority.sv
// mem_arb_priority: IF/DM winner select with a saturating DM-over-IF starvation counter
module mem_arb_priority
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_if_req,
  input  logic i_dm_req,
  input  logic i_idle,
  output logic o_grant,
  output logic o_owner
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] r_starve_cnt;
  logic w_if_forced;
  assign w_if_forced = i_if_req && (r_starve_cnt == SW'(STARVE_MAX));
  assign o_owner = (i_dm_req && !w_if_forced) ? OWNER_DM : OWNER_IF;
  assign o_grant = i_idle && (i_if_req || i_dm_req);
  // a DM win with IF waiting implies the count is below STARVE_MAX, so +1 never wraps
  always_ff @(posedge clk_i) begin
    if (rst_i) r_starve_cnt <= '0;
    else if (o_grant) r_starve_cnt <= (o_owner == OWNER_IF) ? '0 : r_starve_cnt + SW'(i_if_req);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-port memory between CPU instruction-fetch and data ports
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  state_t            r_state;
  logic [CW-1:0]     r_lat_cnt;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_ack;
  logic              r_dm_ack;
  logic              w_grant;
  logic              w_owner;

  mem_arb_priority #(.STARVE_MAX(STARVE_MAX)) u_priority (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_if_req(if_req_i),
    .i_dm_req(dm_req_i),
    .i_idle  (r_state == IDLE),
    .o_grant (w_grant),
    .o_owner (w_owner)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_lat_cnt  <= '0;
      r_owner    <= OWNER_IF;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_if_ack   <= 1'b0;
      r_dm_ack   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_grant) begin
          r_state <= ISSUE;
          r_owner <= w_owner;
          r_we    <= (w_owner == OWNER_DM) && dm_we_i;
          r_addr  <= (w_owner == OWNER_DM) ? dm_addr_i : if_addr_i;
          r_wdata <= (w_owner == OWNER_DM) ? dm_wdata_i : '0;
        end
        ISSUE: begin
          r_lat_cnt <= CW'(MEM_LATENCY - 1);
          r_state   <= (MEM_LATENCY == 1) ? CAPTURE : WAIT;
        end
        WAIT: begin
          r_lat_cnt <= r_lat_cnt - CW'(1);
          if (r_lat_cnt == CW'(1)) r_state <= CAPTURE;
        end
        CAPTURE: begin
          if (!r_we && r_owner == OWNER_IF) r_if_rdata <= mem_rdata_i;
          if (!r_we && r_owner == OWNER_DM) r_dm_rdata <= mem_rdata_i;
          r_if_ack <= (r_owner == OWNER_IF);
          r_dm_ack <= (r_owner == OWNER_DM);
          r_state  <= DONE;
        end
        DONE: begin
          r_if_ack <= 1'b0;
          r_dm_ack <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_en_o    = (r_state == ISSUE);
  assign mem_we_o    = mem_en_o && r_we;
  assign mem_addr_o  = mem_en_o ? r_addr : '0;
  assign mem_wdata_o = mem_en_o ? r_wdata : '0;
  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign if_ack_o    = r_if_ack;
  assign dm_ack_o    = r_dm_ack;
  // low in the ack cycle so the CPU advances at the end of it
  assign stall_o     = (if_req_i && !r_if_ack) || (dm_req_i && !r_dm_ack);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks plus randomized scoreboard run against a transaction-level model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic if_req_i, dm_req_i, dm_we_i, if_ack_o, dm_ack_o, mem_en_o, mem_we_o, stall_o;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, if_rdata_o, dm_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic if_req1, dm_req1, dm_we1, if_ack1, dm_ack1, mem_en1, mem_we1, stall1;
  logic [31:0] if_addr1, dm_addr1, dm_wdata1, if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(2), .STARVE_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o));

  mem_arbiter #(.MEM_LATENCY(1), .STARVE_MAX(4)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req1), .if_addr_i(if_addr1), .if_rdata_o(if_rdata1), .if_ack_o(if_ack1),
    .dm_req_i(dm_req1), .dm_we_i(dm_we1), .dm_addr_i(dm_addr1), .dm_wdata_i(dm_wdata1),
    .dm_rdata_o(dm_rdata1), .dm_ack_o(dm_ack1),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1),
    .mem_rdata_i(mem_rdata1), .stall_o(stall1));

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int w);
    return (w == 1) ? 32'h2002_0005 : (32'h9E37_79B9 * (w + 1)) ^ 32'h5A5A_0000;
  endfunction

  // memory model: unwritten words read as init_word, data appears 2 cycles after the strobe
  logic [31:0] mem [0:127];
  logic [127:0] mem_vld = '0;
  logic [31:0] rd_d1;
  logic [6:0] mw;
  assign mw = mem_addr_o[8:2];
  always @(posedge clk) begin
    if (mem_en_o && mem_we_o) begin
      mem[mw] <= mem_wdata_o;
      mem_vld[mw] <= 1'b1;
    end
    rd_d1 <= (mem_en_o && !mem_we_o) ? (mem_vld[mw] ? mem[mw] : init_word(int'(mw))) : $urandom;
    mem_rdata_i <= rd_d1;
  end
  always @(posedge clk)
    mem_rdata1 <= (mem_en1 && !mem_we1 && mem_addr1 == 32'h20) ? 32'h1234_5678 : $urandom;

  // reference memory, updated in request order by the bench itself
  logic [31:0] ref_mem [0:127];
  logic [127:0] ref_vld = '0;
  function automatic logic [31:0] ref_rd(input int w);
    return ref_vld[w] ? ref_mem[w] : init_word(w);
  endfunction
  task automatic ref_wr(input int w, input logic [31:0] d);
    ref_mem[w] = d;
    ref_vld[w] = 1'b1;
  endtask

  logic [31:0] exp_if_q[$], exp_dm_q[$];
  logic [31:0] cur_if_addr = 0, cur_dm_addr = 0, cur_dm_wdata = 0, last_dm = 0;
  logic cur_dm_we = 0, p_if = 0, p_dm = 0, sb_on = 0, own, exp_own;
  int m_starve = 0, iss_if = 0, iss_dm = 0;

  // monitor: grant order, issue contents, ack data and latency
  always @(negedge clk) begin
    if (sb_on && mem_en_o) begin
      own = mem_addr_o[8];
      exp_own = p_dm && !(p_if && m_starve == 4);
      chk("grant_owner", own, exp_own);
      m_starve = !exp_own ? 0 : (p_if ? ((m_starve < 4) ? m_starve + 1 : 4) : m_starve);
      if (own) begin
        chk("dm_issue_addr", mem_addr_o, cur_dm_addr);
        chk("dm_issue_we", mem_we_o, cur_dm_we);
        if (cur_dm_we) chk("dm_issue_wdata", mem_wdata_o, cur_dm_wdata);
        iss_dm = cyc;
      end else begin
        chk("if_issue_addr", mem_addr_o, cur_if_addr);
        chk("if_issue_we", mem_we_o, 0);
        iss_if = cyc;
      end
    end
    if (sb_on && if_ack_o) begin
      chk("if_ack_pending", exp_if_q.size() != 0, 1);
      if (exp_if_q.size() != 0) chk("if_rdata", if_rdata_o, exp_if_q.pop_front());
      chk("if_latency", cyc - iss_if, 3);
    end
    if (sb_on && dm_ack_o) begin
      chk("dm_ack_pending", exp_dm_q.size() != 0, 1);
      if (exp_dm_q.size() != 0) chk("dm_rdata", dm_rdata_o, exp_dm_q.pop_front());
      chk("dm_latency", cyc - iss_dm, 3);
    end
    p_if = if_req_i;
    p_dm = dm_req_i;
  end

  task automatic if_driver(input int n);
    int w, t, gap;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        if_req_i = 0;
        repeat (gap) @(posedge clk);
        #1;
      end
      w = $urandom_range(0, 63);
      cur_if_addr = 32'(w * 4);
      if_addr_i = cur_if_addr;
      if_req_i = 1;
      exp_if_q.push_back(ref_rd(w));
      t = 0;
      do begin @(negedge clk); t++; end while (!if_ack_o && t < 100);
      chk("if_ack_timeout", if_ack_o, 1);
      @(posedge clk); #1;
    end
    if_req_i = 0;
  endtask

  task automatic dm_driver(input int n);
    int w, t, gap;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        dm_req_i = 0;
        repeat (gap) @(posedge clk);
        #1;
      end
      w = $urandom_range(64, 127);
      cur_dm_addr = 32'(w * 4);
      cur_dm_we = 1'($urandom_range(0, 1));
      cur_dm_wdata = $urandom;
      if (cur_dm_we) ref_wr(w, cur_dm_wdata);
      else last_dm = ref_rd(w);
      exp_dm_q.push_back(last_dm);
      dm_addr_i = cur_dm_addr;
      dm_we_i = cur_dm_we;
      dm_wdata_i = cur_dm_wdata;
      dm_req_i = 1;
      t = 0;
      do begin @(negedge clk); t++; end while (!dm_ack_o && t < 100);
      chk("dm_ack_timeout", dm_ack_o, 1);
      @(posedge clk); #1;
    end
    dm_req_i = 0;
  endtask

  task automatic if_read(input logic [31:0] a, output int lat, output logic [31:0] d);
    if_addr_i = a;
    if_req_i = 1;
    lat = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (if_ack_o) begin
        lat = t;
        break;
      end
    end
    d = if_rdata_o;
    @(posedge clk); #1;
    if_req_i = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: end of test not reached");
    $fatal(1);
  end

  initial begin
    int lat, n_ack, n_iss, exp_g[6];
    int g[$];
    logic [31:0] d;
    logic a_if, a_dm, bad_ack, bad_en, bad_rd, got_if;
    rst = 1;
    {if_req_i, dm_req_i, dm_we_i} = '0;
    {if_addr_i, dm_addr_i, dm_wdata_i} = '0;
    {if_req1, dm_req1, dm_we1} = '0;
    {if_addr1, dm_addr1, dm_wdata1} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", mem_en_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_if_ack", if_ack_o, 0);
    chk("rst_dm_ack", dm_ack_o, 0);
    chk("rst_if_rdata", if_rdata_o, 0);
    chk("rst_dm_rdata", dm_rdata_o, 0);
    chk("rst_stall", stall_o, 0);
    @(posedge clk); #1;
    rst = 0;
    // single IF read: issue at C+1, ack at C+4
    if_addr_i = 32'h4;
    if_req_i = 1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk($sformatf("t2_mem_en_c%0d", t), mem_en_o, t == 1);
      chk($sformatf("t2_stall_c%0d", t), stall_o, t < 4);
      chk($sformatf("t2_if_ack_c%0d", t), if_ack_o, t == 4);
      if (t == 1) chk("t2_mem_addr", mem_addr_o, 32'h4);
    end
    chk("t2_if_rdata", if_rdata_o, 32'h2002_0005);
    @(posedge clk); #1;
    if_req_i = 0;
    // reset during WAIT aborts the read
    if_addr_i = 32'hC;
    if_req_i = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    if_req_i = 0;
    {bad_ack, bad_en, bad_rd} = '0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j > 0) begin
        bad_ack |= if_ack_o;
        bad_en |= mem_en_o;
        bad_rd |= (if_rdata_o != 0);
      end
      @(posedge clk); #1;
      if (j == 1) rst = 0;
    end
    chk("t1_no_ack", bad_ack, 0);
    chk("t1_no_mem_en", bad_en, 0);
    chk("t1_rdata_cleared", bad_rd, 0);
    if_read(32'h4, lat, d);
    chk("t1_rereq_latency", lat, 4);
    chk("t1_rereq_rdata", d, 32'h2002_0005);
    // simultaneous IF read and DM write: DM first
    if_addr_i = 32'h8;
    if_req_i = 1;
    dm_addr_i = 32'h10;
    dm_we_i = 1;
    dm_wdata_i = 32'hDEAD_BEEF;
    dm_req_i = 1;
    ref_wr(4, 32'hDEAD_BEEF);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      a_if = if_ack_o;
      a_dm = dm_ack_o;
      chk($sformatf("t3_mem_en_c%0d", t), mem_en_o, t == 1 || t == 6);
      if (t == 1) begin
        chk("t3_dm_we", mem_we_o, 1);
        chk("t3_dm_addr", mem_addr_o, 32'h10);
        chk("t3_dm_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      end
      if (t == 6) begin
        chk("t3_if_we", mem_we_o, 0);
        chk("t3_if_addr", mem_addr_o, 32'h8);
      end
      chk($sformatf("t3_dm_ack_c%0d", t), dm_ack_o, t == 4);
      chk($sformatf("t3_if_ack_c%0d", t), if_ack_o, t == 9);
      @(posedge clk); #1;
      if (a_dm) dm_req_i = 0;
      if (a_if) if_req_i = 0;
    end
    dm_we_i = 0;
    chk("t3_dm_rdata_kept", dm_rdata_o, 0);
    chk("t3_if_rdata", if_rdata_o, init_word(2));
    // DM request pulsed while IF access is in flight
    if_addr_i = 32'h14;
    if_req_i = 1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (mem_en_o) break;
    end
    @(posedge clk); #1;
    dm_addr_i = 32'h180;
    dm_req_i = 1;
    @(posedge clk); #1;
    dm_req_i = 0;
    n_ack = 0;
    n_iss = 0;
    got_if = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      n_ack += int'(dm_ack_o);
      n_iss += int'(mem_en_o);
      a_if = if_ack_o;
      got_if |= a_if;
      @(posedge clk); #1;
      if (a_if) if_req_i = 0;
    end
    chk("t6_no_dm_ack", n_ack, 0);
    chk("t6_no_dm_issue", n_iss, 0);
    chk("t6_if_served", got_if, 1);
    // starvation: both held, expect D D D D I D
    exp_g = '{1, 1, 1, 1, 0, 1};
    if_addr_i = 32'h40;
    if_req_i = 1;
    dm_addr_i = 32'h100;
    dm_req_i = 1;
    for (int t = 0; t < 80 && g.size() < 6; t++) begin
      @(negedge clk);
      if (mem_en_o) g.push_back(int'(mem_addr_o[8]));
      a_if = if_ack_o;
      a_dm = dm_ack_o;
      @(posedge clk); #1;
      if (a_dm) dm_addr_i = dm_addr_i + 4;
      if (a_if) if_addr_i = if_addr_i + 4;
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("t4_grant%0d_is_dm", i), (g.size() > i) ? g[i] : 2, exp_g[i]);
    if_req_i = 0;
    dm_req_i = 0;
    repeat (8) @(posedge clk);
    #1;
    // MEM_LATENCY=1 instance: DM read, ack at C+3
    dm_addr1 = 32'h20;
    dm_req1 = 1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      a_dm = dm_ack1;
      chk($sformatf("t5_mem_en_c%0d", t), mem_en1, t == 1);
      chk($sformatf("t5_dm_ack_c%0d", t), dm_ack1, t == 3);
      if (t == 3) chk("t5_dm_rdata", dm_rdata1, 32'h1234_5678);
      @(posedge clk); #1;
      if (a_dm) dm_req1 = 0;
    end
    // randomized traffic against the scoreboard
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    m_starve = 0;
    last_dm = 0;
    sb_on = 1;
    fork
      if_driver(30);
      dm_driver(30);
    join
    repeat (6) @(posedge clk);
    chk("if_queue_drained", exp_if_q.size(), 0);
    chk("dm_queue_drained", exp_dm_q.size(), 0);
    sb_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
